// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, masked, fixed-priority interrupt controller with config port
// Sources latch on rising edges, bit 0 wins; one request in flight until the handler signals eoi.
module irq_controller #(
    parameter int          NSRC     = 8,
    parameter logic [15:0] VEC_BASE = 16'h0008
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NSRC-1:0] i_irq_in,
    input  logic            i_cfg_we,
    input  logic [1:0]      i_cfg_addr,
    input  logic [15:0]     i_cfg_wdata,
    output logic [15:0]     o_cfg_rdata,
    input  logic            i_irq_ack,
    input  logic            i_eoi,
    output logic            o_irq_r,
    output logic [15:0]     o_vector,
    output logic [3:0]      o_irq_id,
    output logic            o_in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    state_t            r_state;
    state_t            w_next_state;
    logic [NSRC-1:0]   r_mask;
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   r_irq_prev;
    logic [3:0]        r_irq_id;
    logic [15:0]       r_vector;

    logic [NSRC-1:0]   w_edges;
    logic [NSRC-1:0]   w_eligible;
    logic [NSRC-1:0]   w_w1c;
    logic [NSRC-1:0]   w_ack_clr;
    logic [NSRC-1:0]   w_pending_next;
    logic [3:0]        w_winner;
    logic [15:0]       w_vector_next;
    logic              w_ack_take;
    logic              w_latch;
    logic              w_mask_we;
    logic [15:0]       w_mask16;
    logic [15:0]       w_pend16;
    logic              w_unused_wdata;

    assign w_edges    = i_irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_mask;
    assign w_mask_we  = i_cfg_we && (i_cfg_addr == ADDR_MASK);
    assign w_w1c      = (i_cfg_we && (i_cfg_addr == ADDR_PENDING)) ? i_cfg_wdata[NSRC-1:0] : '0;
    assign w_ack_take = (r_state == S_REQ) && i_irq_ack;
    assign w_latch    = (r_state == S_IDLE) && (|w_eligible);
    assign w_unused_wdata = &{1'b0, i_cfg_wdata};

    // Scan from the top so the lowest eligible index is the last (winning) assignment.
    always_comb begin
        w_winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ack_clr[i] = w_ack_take && (r_irq_id == 4'(i));
        end
    end

    // New edges are OR'ed in last so a same-cycle set wins over W1C or ack-clear.
    assign w_pending_next = (r_pending & ~w_w1c & ~w_ack_clr) | w_edges;
    assign w_vector_next  = VEC_BASE + {11'd0, w_winner, 1'b0};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask     <= '0;
            r_pending  <= '0;
            r_irq_prev <= '0;
        end else begin
            r_irq_prev <= i_irq_in;
            r_pending  <= w_pending_next;
            if (w_mask_we) begin
                r_mask <= i_cfg_wdata[NSRC-1:0];
            end
        end
    end

    // id and vector are captured on entry to REQ and stay frozen until the next IDLE decision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_id <= '0;
            r_vector <= VEC_BASE;
        end else if (w_latch) begin
            r_irq_id <= w_winner;
            r_vector <= w_vector_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (|w_eligible) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (i_irq_ack) begin
                    w_next_state = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (i_eoi) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign o_irq_r      = (r_state == S_REQ);
    assign o_in_service = (r_state == S_SERVICE);
    assign o_vector     = r_vector;
    assign o_irq_id     = r_irq_id;

    always_comb begin
        w_mask16 = '0;
        w_pend16 = '0;
        w_mask16[NSRC-1:0] = r_mask;
        w_pend16[NSRC-1:0] = r_pending;
        case (i_cfg_addr)
            ADDR_MASK:    o_cfg_rdata = w_mask16;
            ADDR_PENDING: o_cfg_rdata = w_pend16;
            ADDR_STATUS:  o_cfg_rdata = {8'b0, o_in_service, o_irq_r, 2'b0, r_irq_id};
            default:      o_cfg_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed scoreboard bench for irq_controller
module tb_irq_controller;

    localparam int NSRC = 8;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] irq_in;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [15:0]     cfg_wdata;
    logic [15:0]     cfg_rdata;
    logic            irq_ack;
    logic            eoi;
    logic            irq_r;
    logic [15:0]     vector;
    logic [3:0]      irq_id;
    logic            in_service;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc;

    irq_controller #(.NSRC(NSRC), .VEC_BASE(16'h0008)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq_in     (irq_in),
        .i_cfg_we     (cfg_we),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_wdata  (cfg_wdata),
        .o_cfg_rdata  (cfg_rdata),
        .i_irq_ack    (irq_ack),
        .i_eoi        (eoi),
        .o_irq_r      (irq_r),
        .o_vector     (vector),
        .o_irq_id     (irq_id),
        .o_in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = 16'h0000;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse_irq(input logic [NSRC-1:0] m);
        irq_in = irq_in | m;
        tick();
        irq_in = irq_in & ~m;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    // Waits for irq_r, then pops the oldest expected request and compares it.
    task automatic wait_req(input string tag, output int n);
        exp_t e;
        n = 0;
        while (!irq_r && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_irq_r"}, {15'b0, irq_r}, 16'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_id"}, {12'b0, irq_id}, {12'b0, e.id});
            check({tag, "_vec"}, vector, e.vec);
        end else begin
            check({tag, "_queue_nonempty"}, 16'd0, 16'd1);
        end
    endtask

    initial begin
        logic [15:0] rd;
        rst_n = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        irq_ack = 1'b0; eoi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq_r", {15'b0, irq_r}, 16'd0);
        check("rst_vector", vector, 16'h0008);
        check("rst_irq_id", {12'b0, irq_id}, 16'd0);
        check("rst_in_service", {15'b0, in_service}, 16'd0);
        cfg_read(2'd0, rd); check("rst_mask", rd, 16'h0000);
        cfg_read(2'd1, rd); check("rst_pending", rd, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Single source 3
        cfg_write(2'd0, 16'h00FF);
        cfg_read(2'd0, rd); check("mask_rd", rd, 16'h00FF);
        cfg_read(2'd3, rd); check("addr3_rd", rd, 16'h0000);
        exp_q.push_back('{id: 4'd3, vec: 16'h000E});
        pulse_irq(8'h08);
        cfg_read(2'd1, rd); check("t1_pending", rd, 16'h0008);
        check("t1_irq_r_early", {15'b0, irq_r}, 16'd0);
        wait_req("t1", cyc);
        check("t1_latency", 16'(cyc), 16'd1);
        cfg_read(2'd2, rd); check("t1_status", rd, 16'h0043);
        pulse_ack();
        check("t1_ack_irq_r", {15'b0, irq_r}, 16'd0);
        check("t1_in_service", {15'b0, in_service}, 16'd1);
        cfg_read(2'd1, rd); check("t1_pending_clr", rd, 16'h0000);
        cfg_read(2'd2, rd); check("t1_status_svc", rd, 16'h0083);
        pulse_eoi();
        check("t1_eoi_in_service", {15'b0, in_service}, 16'd0);

        // Simultaneous sources 5 and 2: priority order
        exp_q.push_back('{id: 4'd2, vec: 16'h000C});
        exp_q.push_back('{id: 4'd5, vec: 16'h0012});
        pulse_irq(8'h24);
        wait_req("t2a", cyc);
        pulse_ack();
        pulse_eoi();
        wait_req("t2b", cyc);
        check("t2b_latency", 16'(cyc), 16'd1);
        pulse_ack();
        pulse_eoi();

        // Masked source latches, request appears after unmask
        cfg_write(2'd0, 16'h0000);
        exp_q.push_back('{id: 4'd1, vec: 16'h000A});
        pulse_irq(8'h02);
        cfg_read(2'd1, rd); check("t3_pending", rd, 16'h0002);
        repeat (3) tick();
        check("t3_masked_irq_r", {15'b0, irq_r}, 16'd0);
        cfg_write(2'd0, 16'h0002);
        wait_req("t3", cyc);
        check("t3_latency", 16'(cyc), 16'd1);

        // Request is frozen against mask change and W1C
        cfg_write(2'd0, 16'h0000);
        cfg_write(2'd1, 16'h00FF);
        check("t4_irq_r_held", {15'b0, irq_r}, 16'd1);
        check("t4_vector_held", vector, 16'h000A);
        check("t4_id_held", {12'b0, irq_id}, 16'd1);
        cfg_read(2'd1, rd); check("t4_pending_w1c", rd, 16'h0000);
        pulse_ack();
        check("t4_in_service", {15'b0, in_service}, 16'd1);
        pulse_eoi();

        // Ignored pulses and set-beats-clear collision
        cfg_write(2'd0, 16'h00FF);
        pulse_ack();
        check("t5_ack_idle_irq_r", {15'b0, irq_r}, 16'd0);
        check("t5_ack_idle_svc", {15'b0, in_service}, 16'd0);
        exp_q.push_back('{id: 4'd0, vec: 16'h0008});
        pulse_irq(8'h01);
        wait_req("t5a", cyc);
        pulse_eoi();
        check("t5_eoi_req_irq_r", {15'b0, irq_r}, 16'd1);
        check("t5_eoi_req_svc", {15'b0, in_service}, 16'd0);
        irq_in[0] = 1'b1; irq_ack = 1'b1;
        tick();
        irq_in[0] = 1'b0; irq_ack = 1'b0;
        check("t5_collide_svc", {15'b0, in_service}, 16'd1);
        cfg_read(2'd1, rd); check("t5_collide_pending", rd, 16'h0001);
        exp_q.push_back('{id: 4'd0, vec: 16'h0008});
        pulse_eoi();
        wait_req("t5b", cyc);
        check("t5b_latency", 16'(cyc), 16'd1);
        pulse_ack();

        // Asynchronous reset while in service with pending events
        pulse_irq(8'h30);
        cfg_read(2'd1, rd); check("t6_pending_pre", rd, 16'h0030);
        check("t6_svc_pre", {15'b0, in_service}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_irq_r", {15'b0, irq_r}, 16'd0);
        check("t6_in_service", {15'b0, in_service}, 16'd0);
        check("t6_vector", vector, 16'h0008);
        check("t6_irq_id", {12'b0, irq_id}, 16'd0);
        cfg_read(2'd1, rd); check("t6_pending", rd, 16'h0000);
        cfg_read(2'd0, rd); check("t6_mask", rd, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_write(2'd0, 16'h00FF);
        repeat (3) tick();
        check("t6_no_replay", {15'b0, irq_r}, 16'd0);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
